// File: rtl/pack_alloc_pkg.sv
// rtl/pack_alloc_pkg.sv - shared constants, types and ROB index helpers for pack_alloc
//
// Purpose : pack count and width, pointer and ROB index types, and helpers that
//           split a ROB index into its pack ID and slot fields.
// Ports   : none (package).
package pack_alloc_pkg;

   localparam int PACK_W = 4;
   localparam int PACKS  = 1 << PACK_W;

   // rob[PACK_W:1] = pack ID, rob[0] = slot within the pack
   typedef logic [PACK_W:0]   rob_idx_t;
   // Ring pointer; MSB is the wrap bit that tells full apart from empty
   typedef logic [PACK_W:0]   pack_ptr_t;
   typedef logic [PACK_W-1:0] pack_id_t;

   function automatic pack_id_t rob_pack(input rob_idx_t rob);
      return rob[PACK_W:1];
   endfunction

   function automatic logic rob_slot(input rob_idx_t rob);
      return rob[0];
   endfunction

endpackage

// File: rtl/pack_status_tbl.sv
// rtl/pack_status_tbl.sv - per-pack slot valid/done table for pack_alloc
//
// Purpose : holds vld[PACKS][2] and done[PACKS][2]; applies alloc, writeback,
//           commit and flush updates and exposes the head entry.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           flush               clear the whole table (overrides all updates)
//           alloc, alloc_id, alloc_slots   open an entry with its slot mask
//           wb0/wb1, wb0_rob/wb1_rob       mark a slot complete
//           cmt, head_id        retire the head entry; head read index
//           head_vld, head_done slot masks of the head entry
module pack_status_tbl
   import pack_alloc_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   input  logic     alloc,
   input  pack_id_t alloc_id,
   input  logic [1:0] alloc_slots,
   input  logic     wb0,
   input  rob_idx_t wb0_rob,
   input  logic     wb1,
   input  rob_idx_t wb1_rob,
   input  logic     cmt,
   input  pack_id_t head_id,
   output logic [1:0] head_vld,
   output logic [1:0] head_done
);

   logic [PACKS-1:0][1:0] vld;
   logic [PACKS-1:0][1:0] done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld  <= '0;
         done <= '0;
      end else if (flush) begin
         vld  <= '0;
         done <= '0;
      end else begin
         // Writebacks are gated by the registered vld, so a stale ROB index
         // aimed at an unallocated slot leaves no trace.
         if (wb0 && vld[rob_pack(wb0_rob)][rob_slot(wb0_rob)])
            done[rob_pack(wb0_rob)][rob_slot(wb0_rob)] <= 1'b1;
         if (wb1 && vld[rob_pack(wb1_rob)][rob_slot(wb1_rob)])
            done[rob_pack(wb1_rob)][rob_slot(wb1_rob)] <= 1'b1;
         // Commit clears after the writebacks so the retired entry ends empty.
         if (cmt) begin
            vld[head_id]  <= 2'b00;
            done[head_id] <= 2'b00;
         end
         // Alloc and commit never target the same entry: the ring would have
         // to be full, and alloc is blocked then.
         if (alloc) begin
            vld[alloc_id]  <= alloc_slots;
            done[alloc_id] <= 2'b00;
         end
      end
   end

   assign head_vld  = vld[head_id];
   assign head_done = done[head_id];

endmodule

// File: rtl/pack_alloc.sv
// rtl/pack_alloc.sv - pack ID allocator and in-flight pack tracker
//
// Purpose : hands out 4-bit pack IDs to dispatch groups of up to two ALU
//           instructions, drives the instruction RAM write enables, tracks
//           slot completion and retires the oldest pack on commit.
// Ports   : cpu_clk_i, cpu_rst_i          clock, asynchronous active-high reset
//           dsp_valid_i, dsp_ins*_valid_i dispatch group offer and slot mask
//           dsp_ready_o, pack_id_o, ins*_we_o   allocation handshake, RAM writes
//           wb*_valid_i, wb*_rob_i        ALU completion strobes
//           head_pack_o, head_slots_o, head_ready_o   oldest pack status
//           cmt_i, flush_i                retire oldest / discard all
//           occupancy_o, full_o, empty_o  ring status
//           stall_cnt_o, alloc_cnt_o      only with PACK_ALLOC_STATS_EN
module pack_alloc
   import pack_alloc_pkg::*;
(
   input  logic            cpu_clk_i,
   input  logic            cpu_rst_i,
`ifdef PACK_ALLOC_STATS_EN
   output logic [31:0]     stall_cnt_o,
   output logic [31:0]     alloc_cnt_o,
`endif
   input  logic            dsp_valid_i,
   input  logic            dsp_ins0_valid_i,
   input  logic            dsp_ins1_valid_i,
   output logic            dsp_ready_o,
   output logic [PACK_W-1:0] pack_id_o,
   output logic            ins0_we_o,
   output logic            ins1_we_o,
   input  logic            wb0_valid_i,
   input  logic [PACK_W:0] wb0_rob_i,
   input  logic            wb1_valid_i,
   input  logic [PACK_W:0] wb1_rob_i,
   output logic [PACK_W-1:0] head_pack_o,
   output logic [1:0]      head_slots_o,
   output logic            head_ready_o,
   input  logic            cmt_i,
   input  logic            flush_i,
   output logic [PACK_W:0] occupancy_o,
   output logic            full_o,
   output logic            empty_o
);

   pack_ptr_t  head;
   pack_ptr_t  tail;
   logic       empty;
   logic       full;
   logic       alloc_fire;
   logic       cmt_fire;
   logic [1:0] head_vld;
   logic [1:0] head_done;

   assign empty = (head == tail);
   assign full  = (head[PACK_W-1:0] == tail[PACK_W-1:0]) && (head[PACK_W] != tail[PACK_W]);

   // Ready looks only at registered state: a commit in this cycle does not
   // open a slot until the next one.
   assign dsp_ready_o = !full && !flush_i;
   assign alloc_fire  = dsp_valid_i && dsp_ready_o && (dsp_ins0_valid_i || dsp_ins1_valid_i);
   assign ins0_we_o   = alloc_fire && dsp_ins0_valid_i;
   assign ins1_we_o   = alloc_fire && dsp_ins1_valid_i;

   assign head_ready_o = !empty && (&(~head_vld | head_done));
   assign cmt_fire     = cmt_i && head_ready_o && !flush_i;

   always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
      if (cpu_rst_i) begin
         head <= '0;
         tail <= '0;
      end else if (flush_i) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (alloc_fire) tail <= tail + pack_ptr_t'(1);
         if (cmt_fire)   head <= head + pack_ptr_t'(1);
      end
   end

   pack_status_tbl u_tbl (
      .clk         (cpu_clk_i),
      .rst         (cpu_rst_i),
      .flush       (flush_i),
      .alloc       (alloc_fire),
      .alloc_id    (tail[PACK_W-1:0]),
      .alloc_slots ({dsp_ins1_valid_i, dsp_ins0_valid_i}),
      .wb0         (wb0_valid_i),
      .wb0_rob     (wb0_rob_i),
      .wb1         (wb1_valid_i),
      .wb1_rob     (wb1_rob_i),
      .cmt         (cmt_fire),
      .head_id     (head[PACK_W-1:0]),
      .head_vld    (head_vld),
      .head_done   (head_done)
   );

   assign pack_id_o    = tail[PACK_W-1:0];
   assign head_pack_o  = head[PACK_W-1:0];
   assign head_slots_o = head_vld;
   assign occupancy_o  = tail - head;
   assign full_o       = full;
   assign empty_o      = empty;

`ifdef PACK_ALLOC_STATS_EN
   // Saturating event counters; flush leaves them alone.
   always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
      if (cpu_rst_i) begin
         stall_cnt_o <= '0;
         alloc_cnt_o <= '0;
      end else begin
         if (dsp_valid_i && !dsp_ready_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 32'd1;
         if (alloc_fire && (alloc_cnt_o != '1))
            alloc_cnt_o <= alloc_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pack_alloc.sv
// tb/tb_pack_alloc.sv - self-checking bench for pack_alloc
module tb_pack_alloc;

   logic       clk = 1'b0;
   logic       rst;
   logic       dsp_valid, ins0_v, ins1_v;
   logic       dsp_ready;
   logic [3:0] pack_id;
   logic       we0, we1;
   logic       wb0_v, wb1_v;
   logic [4:0] wb0_rob, wb1_rob;
   logic [3:0] head_pack;
   logic [1:0] head_slots;
   logic       head_ready;
   logic       cmt, flush;
   logic [4:0] occ;
   logic       full, empty;
`ifdef PACK_ALLOC_STATS_EN
   logic [31:0] stall_cnt, alloc_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pack_alloc dut (
      .cpu_clk_i        (clk),
      .cpu_rst_i        (rst),
`ifdef PACK_ALLOC_STATS_EN
      .stall_cnt_o      (stall_cnt),
      .alloc_cnt_o      (alloc_cnt),
`endif
      .dsp_valid_i      (dsp_valid),
      .dsp_ins0_valid_i (ins0_v),
      .dsp_ins1_valid_i (ins1_v),
      .dsp_ready_o      (dsp_ready),
      .pack_id_o        (pack_id),
      .ins0_we_o        (we0),
      .ins1_we_o        (we1),
      .wb0_valid_i      (wb0_v),
      .wb0_rob_i        (wb0_rob),
      .wb1_valid_i      (wb1_v),
      .wb1_rob_i        (wb1_rob),
      .head_pack_o      (head_pack),
      .head_slots_o     (head_slots),
      .head_ready_o     (head_ready),
      .cmt_i            (cmt),
      .flush_i          (flush),
      .occupancy_o      (occ),
      .full_o           (full),
      .empty_o          (empty)
   );

   typedef struct {
      logic       dv, i0, i1, w0v;
      logic [4:0] w0r;
      logic       w1v;
      logic [4:0] w1r;
      logic       c, f;
      logic       e_rdy;
      logic [3:0] e_pid;
      logic       e_we0, e_we1;
      logic [3:0] e_hp;
      logic [1:0] e_hs;
      logic       e_hr;
      logic [4:0] e_occ;
      logic       e_full, e_empty;
   } vec_t;

   function automatic vec_t mk(
      input logic dv, input logic i0, input logic i1,
      input logic w0v, input logic [4:0] w0r, input logic w1v, input logic [4:0] w1r,
      input logic c, input logic f,
      input logic rdy, input logic [3:0] pid, input logic e0, input logic e1,
      input logic [3:0] hp, input logic [1:0] hs, input logic hr,
      input logic [4:0] oc, input logic fu, input logic em);
      vec_t v;
      v.dv = dv; v.i0 = i0; v.i1 = i1; v.w0v = w0v; v.w0r = w0r;
      v.w1v = w1v; v.w1r = w1r; v.c = c; v.f = f;
      v.e_rdy = rdy; v.e_pid = pid; v.e_we0 = e0; v.e_we1 = e1;
      v.e_hp = hp; v.e_hs = hs; v.e_hr = hr; v.e_occ = oc;
      v.e_full = fu; v.e_empty = em;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      dsp_valid = 0; ins0_v = 0; ins1_v = 0;
      wb0_v = 0; wb0_rob = '0; wb1_v = 0; wb1_rob = '0;
      cmt = 0; flush = 0;
   endtask

   // Entered and left at posedge+1: drive, settle, compare, clock.
   task automatic run_vec(input vec_t v, input string tag);
      dsp_valid = v.dv; ins0_v = v.i0; ins1_v = v.i1;
      wb0_v = v.w0v; wb0_rob = v.w0r; wb1_v = v.w1v; wb1_rob = v.w1r;
      cmt = v.c; flush = v.f;
      #1;
      chk({tag, " ready"},      32'(dsp_ready),  32'(v.e_rdy));
      chk({tag, " pack_id"},    32'(pack_id),    32'(v.e_pid));
      chk({tag, " we0"},        32'(we0),        32'(v.e_we0));
      chk({tag, " we1"},        32'(we1),        32'(v.e_we1));
      chk({tag, " head_pack"},  32'(head_pack),  32'(v.e_hp));
      chk({tag, " head_slots"}, 32'(head_slots), 32'(v.e_hs));
      chk({tag, " head_ready"}, 32'(head_ready), 32'(v.e_hr));
      chk({tag, " occupancy"},  32'(occ),        32'(v.e_occ));
      chk({tag, " full"},       32'(full),       32'(v.e_full));
      chk({tag, " empty"},      32'(empty),      32'(v.e_empty));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   vec_t tbl_a[18];

   initial begin
      // basic alloc / writeback / commit table, starting from reset
      tbl_a[0]  = mk(0,0,0, 0,0,0,0, 0,0,  1,0,0,0, 0,0,0, 0,0,1);
      tbl_a[1]  = mk(1,1,0, 0,0,0,0, 0,0,  1,0,1,0, 0,0,0, 0,0,1);
      tbl_a[2]  = mk(0,0,0, 1,0,0,0, 0,0,  1,1,0,0, 0,1,0, 1,0,0);
      tbl_a[3]  = mk(0,0,0, 0,0,0,0, 1,0,  1,1,0,0, 0,1,1, 1,0,0);
      tbl_a[4]  = mk(0,0,0, 0,0,0,0, 0,0,  1,1,0,0, 1,0,0, 0,0,1);
      tbl_a[5]  = mk(1,0,0, 0,0,0,0, 0,0,  1,1,0,0, 1,0,0, 0,0,1);
      tbl_a[6]  = mk(0,0,0, 0,0,0,0, 0,0,  1,1,0,0, 1,0,0, 0,0,1);
      tbl_a[7]  = mk(1,1,1, 0,0,0,0, 0,0,  1,1,1,1, 1,0,0, 0,0,1);
      tbl_a[8]  = mk(0,0,0, 0,0,1,3, 0,0,  1,2,0,0, 1,3,0, 1,0,0);
      tbl_a[9]  = mk(0,0,0, 0,0,0,0, 1,0,  1,2,0,0, 1,3,0, 1,0,0);
      tbl_a[10] = mk(0,0,0, 1,2,0,0, 1,0,  1,2,0,0, 1,3,0, 1,0,0);
      tbl_a[11] = mk(0,0,0, 0,0,0,0, 0,0,  1,2,0,0, 1,3,1, 1,0,0);
      tbl_a[12] = mk(1,0,1, 0,0,0,0, 1,0,  1,2,0,1, 1,3,1, 1,0,0);
      tbl_a[13] = mk(0,0,0, 0,0,0,0, 0,0,  1,3,0,0, 2,2,0, 1,0,0);
      tbl_a[14] = mk(0,0,0, 1,4,1,5, 0,0,  1,3,0,0, 2,2,0, 1,0,0);
      tbl_a[15] = mk(0,0,0, 0,0,0,0, 0,0,  1,3,0,0, 2,2,1, 1,0,0);
      tbl_a[16] = mk(0,0,0, 0,0,0,0, 1,0,  1,3,0,0, 2,2,1, 1,0,0);
      tbl_a[17] = mk(0,0,0, 0,0,0,0, 0,0,  1,3,0,0, 3,0,0, 0,0,1);

      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      for (int i = 0; i < 18; i++) run_vec(tbl_a[i], $sformatf("basic[%0d]", i));

      // fill all 16 packs, then stall, then commit+dispatch while full
      do_reset();
      for (int i = 0; i < 16; i++)
         run_vec(mk(1,1,1, 0,0,0,0, 0,0, 1,4'(i),1,1, 0,(i==0)?2'b00:2'b11,0, 5'(i),0,(i==0)),
                 $sformatf("fill[%0d]", i));
      run_vec(mk(0,0,0, 0,0,0,0, 0,0,  0,0,0,0, 0,3,0, 16,1,0), "full");
      for (int i = 0; i < 3; i++)
         run_vec(mk(1,1,1, 0,0,0,0, 0,0, 0,0,0,0, 0,3,0, 16,1,0), $sformatf("stall[%0d]", i));
`ifdef PACK_ALLOC_STATS_EN
      chk("stall_cnt after 3", stall_cnt, 32'd3);
      chk("alloc_cnt after fill", alloc_cnt, 32'd16);
`endif
      run_vec(mk(0,0,0, 1,0,1,1, 0,0,  0,0,0,0, 0,3,0, 16,1,0), "full wb");
      run_vec(mk(1,1,1, 0,0,0,0, 1,0,  0,0,0,0, 0,3,1, 16,1,0), "full cmt+dv");
      run_vec(mk(1,1,1, 0,0,0,0, 0,0,  1,0,1,1, 1,3,0, 15,0,0), "wrap alloc");
      run_vec(mk(0,0,0, 0,0,0,0, 0,0,  0,1,0,0, 1,3,0, 16,1,0), "wrap full");

      // flush with 5 packs in flight and a stale writeback afterwards
      do_reset();
`ifdef PACK_ALLOC_STATS_EN
      chk("stall_cnt reset", stall_cnt, 32'd0);
`endif
      for (int i = 0; i < 5; i++)
         run_vec(mk(1,1,1, 0,0,0,0, 0,0, 1,4'(i),1,1, 0,(i==0)?2'b00:2'b11,0, 5'(i),0,(i==0)),
                 $sformatf("pre[%0d]", i));
      run_vec(mk(1,1,1, 0,0,0,0, 0,1,  0,5,0,0, 0,3,0, 5,0,0), "flush");
      run_vec(mk(0,0,0, 0,0,1,3, 0,0,  1,0,0,0, 0,0,0, 0,0,1), "post flush");
      run_vec(mk(1,1,1, 0,0,0,0, 0,0,  1,0,1,1, 0,0,0, 0,0,1), "realloc0");
      run_vec(mk(1,1,1, 0,0,0,0, 0,0,  1,1,1,1, 0,3,0, 1,0,0), "realloc1");
      run_vec(mk(0,0,0, 1,0,1,1, 0,0,  1,2,0,0, 0,3,0, 2,0,0), "wb pack0");
      run_vec(mk(0,0,0, 0,0,0,0, 1,0,  1,2,0,0, 0,3,1, 2,0,0), "cmt pack0");
      run_vec(mk(0,0,0, 0,0,0,0, 0,0,  1,2,0,0, 1,3,0, 1,0,0), "head1");
      run_vec(mk(0,0,0, 1,2,0,0, 0,0,  1,2,0,0, 1,3,0, 1,0,0), "wb rob2");
      run_vec(mk(0,0,0, 0,0,0,0, 0,0,  1,2,0,0, 1,3,0, 1,0,0), "stale rob3");

      // asynchronous reset between clock edges
      #2 rst = 1;
      #1;
      chk("async empty", 32'(empty), 32'd1);
      chk("async occupancy", 32'(occ), 32'd0);
      chk("async pack_id", 32'(pack_id), 32'd0);
      chk("async head_slots", 32'(head_slots), 32'd0);
`ifdef PACK_ALLOC_STATS_EN
      chk("async alloc_cnt", alloc_cnt, 32'd0);
`endif
      @(posedge clk); #1 rst = 0;
      run_vec(mk(0,0,0, 0,0,0,0, 0,0,  1,0,0,0, 0,0,0, 0,0,1), "after async");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pack_alloc.md
Name: pack_alloc

Overview:
- Allocates 4-bit pack IDs to dispatch groups of up to two ALU instructions, and drives the write enables of the two-slot, 16-pack instruction RAM.
- Tracks per-slot validity and completion for every in-flight pack. Signals when the oldest pack may retire, and frees it on commit.
- Sits between rename/dispatch, the ALU writeback ports and the commit stage.
- ROB index encoding is shared with the instruction RAM: rob[4:1] = pack ID, rob[0] = slot (0 = ins0, 1 = ins1).

Parameters:
- PACKS, 16, number of packs; must be a power of two.
- PACK_W, 4, pack ID width, equal to log2(PACKS).

Ports:
- cpu_clk_i  in  1  clock.
- cpu_rst_i  in  1  reset, asynchronous, active-high.
- dsp_valid_i  in  1  a dispatch group is offered.
- dsp_ins0_valid_i  in  1  slot 0 of the group holds an instruction.
- dsp_ins1_valid_i  in  1  slot 1 of the group holds an instruction.
- dsp_ready_o  out  1  allocation possible this cycle.
- pack_id_o  out  PACK_W  pack ID for the current group (tail pointer), to the RAM pack_id.
- ins0_we_o  out  1  slot 0 RAM write enable.
- ins1_we_o  out  1  slot 1 RAM write enable.
- wb0_valid_i  in  1  ALU0 completion strobe.
- wb0_rob_i  in  PACK_W+1  ALU0 completed ROB index.
- wb1_valid_i  in  1  ALU1 completion strobe.
- wb1_rob_i  in  PACK_W+1  ALU1 completed ROB index.
- head_pack_o  out  PACK_W  oldest pack ID.
- head_slots_o  out  2  valid-slot mask of the oldest pack.
- head_ready_o  out  1  oldest pack is fully complete.
- cmt_i  in  1  retire the oldest pack.
- flush_i  in  1  discard all packs.
- occupancy_o  out  PACK_W+1  number of packs in flight.
- full_o  out  1  all packs in flight.
- empty_o  out  1  no packs in flight.

Behaviour:
- State: head and tail pointers, PACK_W+1 bits each (MSB is the wrap bit); vld[PACKS][2]; done[PACKS][2].
- Reset: head=0, tail=0, all vld=0, all done=0.
- Outputs at reset: dsp_ready_o=1, pack_id_o=0, ins*_we_o=0, head_pack_o=0, head_slots_o=0, head_ready_o=0, occupancy_o=0, full_o=0, empty_o=1.
- Status decode:
  - empty = (head==tail).
  - full = (head[PACK_W-1:0]==tail[PACK_W-1:0]) with differing MSBs.
  - occupancy = tail-head, modulo 2^(PACK_W+1).
- dsp_ready_o = !full && !flush_i. Purely combinational from registered state; no same-cycle commit bypass.
- Allocation fires when dsp_valid_i && dsp_ready_o && (ins0 || ins1):
  - insN_we_o = fire && dsp_insN_valid_i, combinational and same cycle, so the RAM write lands at pack_id_o.
  - Next cycle: vld[tail] = {ins1,ins0}, done[tail] = 00, tail+1.
- A group with both slot valids low is a no-op: no allocation, no write enables.
- Writeback: wbN_valid_i sets done[rob[4:1]][rob[0]] next cycle. It is ignored if that slot's vld is 0. Both ports may hit the same or different entries in the same cycle; both take effect.
- head_ready_o = !empty && for each slot s (!vld[head][s] || done[head][s]).
- head_pack_o = head[PACK_W-1:0]. head_slots_o = vld[head].
- Commit fires when cmt_i && head_ready_o: clear vld/done[head], head+1. cmt_i without head_ready_o is ignored.
- Writeback to the head pack and commit in the same cycle: commit uses the registered done, so it does not retire that cycle.
- Alloc and commit in the same cycle: both apply and occupancy is unchanged. When full, alloc is blocked even if a commit fires.
- Wrap-around: pointers increment modulo 2^(PACK_W+1); pack ID 15 is followed by 0.
- flush_i has priority over alloc, writeback and commit: next cycle head=tail=0, all vld/done cleared, and write enables are forced to 0 in the flush cycle.
- Asynchronous reset mid-operation returns all state to the reset values immediately.

Optional Feature:
- Macro: PACK_ALLOC_STATS_EN.
- When defined:
  - Adds output stall_cnt_o, 32 bits: counts cycles with dsp_valid_i && !dsp_ready_o, saturates at 0xFFFFFFFF.
  - Adds output alloc_cnt_o, 32 bits: counts allocations, saturates.
  - Both reset to 0; flush does not clear them.
- When undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - PACK_W and PACKS constants.
  - typedef rob_idx_t as logic [PACK_W:0], with helper functions rob_pack() and rob_slot().
  - typedef pack_ptr_t as logic [PACK_W:0].
- One sub-module, pack_status_tbl: the vld/done arrays with alloc/writeback/commit/flush update ports and the head read port. Pointer logic stays in pack_alloc.

Test Plan:
- Reset, then 16 groups with {ins0,ins1}=11 → pack_id_o 0..15, full_o=1 and dsp_ready_o=0 after the 16th, occupancy_o=16.
- Alloc pack 0 with ins0 only; wb0_rob_i=5'b00000 → head_ready_o=1 next cycle, head_slots_o=01; cmt_i → empty_o=1.
- Alloc pack 0 with both slots; wb1 on rob 1 only → head_ready_o=0; wb0 on rob 0 → head_ready_o=1.
- Full queue with head ready; cmt_i and dsp_valid_i in the same cycle → commit taken, allocation refused that cycle, accepted next cycle with pack_id_o=0 (wrap).
- 5 packs in flight, flush_i with dsp_valid_i high → ins*_we_o=0, next cycle empty_o=1 and pack_id_o=0; a stale writeback to rob 3 has no effect.
- Build with PACK_ALLOC_STATS_EN; hold dsp_valid_i high for 3 cycles while full → stall_cnt_o=3; reset → 0.
